// File: rtl/ntt_pkg.sv
// rtl/ntt_pkg.sv - shared modular helpers, pipeline depth and beat type for the radix-8 NTT pipe
package ntt_pkg;

    localparam int NTT_R8_LATENCY = 5;
    localparam int NTT_MAX_WIDTH  = 32;

    typedef struct packed {
        logic                             mode;
        logic [7:0][NTT_MAX_WIDTH-1:0]    data;
        logic [6:0][NTT_MAX_WIDTH-1:0]    twiddle;
    } ntt_beat_t;

    // Operands are < q, so one conditional correction fully reduces the result
    function automatic logic [31:0] mod_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] q);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, q})
            s = s - {1'b0, q};
        return s[31:0];
    endfunction

    function automatic logic [31:0] mod_sub(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] q);
        logic [32:0] d;
        d = {1'b0, a} - {1'b0, b};
        if (d[32])
            d = d + {1'b0, q};
        return d[31:0];
    endfunction

endpackage

// File: rtl/mod_mul.sv
// rtl/mod_mul.sv - combinational (a*b) mod Q with a full-width product
module mod_mul #(
    parameter int WIDTH = 5,
    parameter int Q     = 17
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] p
);

    logic [2*WIDTH-1:0] prod;

    assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    assign p    = WIDTH'(prod % (2*WIDTH)'(Q));

endmodule

// File: rtl/ntt_radix8_pipe.sv
// rtl/ntt_radix8_pipe.sv - five-stage pipelined radix-8 NTT/INTT butterfly with valid/ready stream
module ntt_radix8_pipe
    import ntt_pkg::*;
#(
    parameter int WIDTH  = 5,
    parameter int Q      = 17,
    parameter int W8     = 2,
    parameter int W8_INV = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_mode,
    input  logic [8*WIDTH-1:0]   in_data,
    input  logic [7*WIDTH-1:0]   in_twiddle,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*WIDTH-1:0]   out_data
);

    localparam logic [31:0] QW  = 32'(Q);
    localparam longint      FW1 = longint'(W8) % Q;
    localparam longint      FW2 = (FW1 * W8) % Q;
    localparam longint      FW3 = (FW2 * W8) % Q;
    localparam longint      IW1 = longint'(W8_INV) % Q;
    localparam longint      IW2 = (IW1 * W8_INV) % Q;
    localparam longint      IW3 = (IW2 * W8_INV) % Q;

    logic                          adv;
    logic [NTT_R8_LATENCY-1:0]     vld;
    logic [NTT_R8_LATENCY-2:0]     mde;
    logic [7:0][WIDTH-1:0]         x, n1, n2, n3, n4, n5, d1, d2, d3, d4, d5;
    logic [6:0][WIDTH-1:0]         tw, t1, t2, t3, t4;
    logic [WIDTH-1:0]              c3;
    logic [3:1][WIDTH-1:0]         c4;

    assign adv       = !vld[NTT_R8_LATENCY-1] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld[NTT_R8_LATENCY-1];
    assign out_data  = d5;
    assign x         = in_data;
    assign tw        = in_twiddle;

    // S1: twiddle pre-multiply for NTT beats
    assign n1[0] = x[0];
    for (genvar j = 1; j < 8; j++) begin : g_s1
        logic [WIDTH-1:0] prod;
        mod_mul #(.WIDTH(WIDTH), .Q(Q)) u_mul (.a(x[j]), .b(tw[j-1]), .p(prod));
        assign n1[j] = in_mode ? x[j] : prod;
    end

    // S2: span-1 butterflies; input bit-reversal is folded into the operand indices
    for (genvar p = 0; p < 4; p++) begin : g_s2
        localparam int LO = ((p % 2) * 2) + (p / 2);
        assign n2[2*p]   = WIDTH'(mod_add(32'(d1[LO]), 32'(d1[LO+4]), QW));
        assign n2[2*p+1] = WIDTH'(mod_sub(32'(d1[LO]), 32'(d1[LO+4]), QW));
    end

    // S3: span-2 butterflies, rotation W^2
    assign c3 = mde[1] ? WIDTH'(IW2) : WIDTH'(FW2);
    for (genvar g = 0; g < 2; g++) begin : g_s3
        for (genvar j = 0; j < 2; j++) begin : g_bf
            localparam int I = 4*g + j;
            logic [WIDTH-1:0] v;
            if (j == 0) begin : g_unit
                assign v = d2[I+2];
            end else begin : g_rot
                mod_mul #(.WIDTH(WIDTH), .Q(Q)) u_mul (.a(d2[I+2]), .b(c3), .p(v));
            end
            assign n3[I]   = WIDTH'(mod_add(32'(d2[I]), 32'(v), QW));
            assign n3[I+2] = WIDTH'(mod_sub(32'(d2[I]), 32'(v), QW));
        end
    end

    // S4: span-4 butterflies, rotations W^1..W^3
    assign c4[1] = mde[2] ? WIDTH'(IW1) : WIDTH'(FW1);
    assign c4[2] = mde[2] ? WIDTH'(IW2) : WIDTH'(FW2);
    assign c4[3] = mde[2] ? WIDTH'(IW3) : WIDTH'(FW3);
    for (genvar j = 0; j < 4; j++) begin : g_s4
        logic [WIDTH-1:0] v;
        if (j == 0) begin : g_unit
            assign v = d3[4];
        end else begin : g_rot
            mod_mul #(.WIDTH(WIDTH), .Q(Q)) u_mul (.a(d3[j+4]), .b(c4[j]), .p(v));
        end
        assign n4[j]   = WIDTH'(mod_add(32'(d3[j]), 32'(v), QW));
        assign n4[j+4] = WIDTH'(mod_sub(32'(d3[j]), 32'(v), QW));
    end

    // S5: twiddle post-multiply for INTT beats
    assign n5[0] = d4[0];
    for (genvar k = 1; k < 8; k++) begin : g_s5
        logic [WIDTH-1:0] prod;
        mod_mul #(.WIDTH(WIDTH), .Q(Q)) u_mul (.a(d4[k]), .b(t4[k-1]), .p(prod));
        assign n5[k] = mde[3] ? prod : d4[k];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            mde <= '0;
            d1  <= '0;
            d2  <= '0;
            d3  <= '0;
            d4  <= '0;
            d5  <= '0;
            t1  <= '0;
            t2  <= '0;
            t3  <= '0;
            t4  <= '0;
        end else if (adv) begin
            vld <= {vld[NTT_R8_LATENCY-2:0], in_valid};
            mde <= {mde[NTT_R8_LATENCY-3:0], in_mode};
            d1  <= n1;
            d2  <= n2;
            d3  <= n3;
            d4  <= n4;
            d5  <= n5;
            t1  <= tw;
            t2  <= t1;
            t3  <= t2;
            t4  <= t3;
        end
    end

endmodule

// File: tb/tb_ntt_radix8_pipe.sv
// tb/tb_ntt_radix8_pipe.sv - directed-vector and scoreboard bench for ntt_radix8_pipe
module tb_ntt_radix8_pipe;

    localparam int WIDTH = 5;
    localparam int Q     = 17;
    localparam int DW    = 8*WIDTH;
    localparam int TW    = 7*WIDTH;

    typedef struct {
        logic          mode;
        logic [DW-1:0] x;
        logic [TW-1:0] t;
        logic [DW-1:0] y;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_mode = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [TW-1:0] in_twiddle = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;

    int            checks = 0;
    int            errors = 0;
    int            outs = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] pending_exp = '0;
    logic [DW-1:0] held = '0;
    logic          stalled = 1'b0;
    logic          accepted = 1'b0;

    always #5 clk = ~clk;

    ntt_radix8_pipe #(.WIDTH(WIDTH), .Q(Q), .W8(2), .W8_INV(9)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_mode    (in_mode),
        .in_data    (in_data),
        .in_twiddle (in_twiddle),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
    );

    function automatic logic [DW-1:0] p8(input int a0, input int a1, input int a2, input int a3,
                                         input int a4, input int a5, input int a6, input int a7);
        return {WIDTH'(a7), WIDTH'(a6), WIDTH'(a5), WIDTH'(a4),
                WIDTH'(a3), WIDTH'(a2), WIDTH'(a1), WIDTH'(a0)};
    endfunction

    function automatic logic [TW-1:0] p7(input int a1, input int a2, input int a3, input int a4,
                                         input int a5, input int a6, input int a7);
        return {WIDTH'(a7), WIDTH'(a6), WIDTH'(a5), WIDTH'(a4),
                WIDTH'(a3), WIDTH'(a2), WIDTH'(a1)};
    endfunction

    function automatic vec_t mk(input logic m, input logic [DW-1:0] xv,
                                input logic [TW-1:0] tv, input logic [DW-1:0] yv);
        vec_t v;
        v.mode = m;
        v.x    = xv;
        v.t    = tv;
        v.y    = yv;
        return v;
    endfunction

    // Direct O(n^2) transform straight from the defining sums
    function automatic logic [DW-1:0] model(input logic m, input logic [DW-1:0] xd,
                                            input logic [TW-1:0] td);
        int tw[8];
        int a[8];
        int w, acc, pw;
        logic [DW-1:0] r;
        tw[0] = 1;
        for (int j = 1; j < 8; j++) tw[j] = int'(td[(j-1)*WIDTH +: WIDTH]);
        w = m ? 9 : 2;
        for (int j = 0; j < 8; j++)
            a[j] = m ? int'(xd[j*WIDTH +: WIDTH]) : (int'(xd[j*WIDTH +: WIDTH]) * tw[j]) % Q;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            acc = 0;
            for (int j = 0; j < 8; j++) begin
                pw = 1;
                for (int e = 0; e < (j*k) % 8; e++) pw = (pw * w) % Q;
                acc = (acc + a[j] * pw) % Q;
            end
            if (m) acc = (acc * tw[k]) % Q;
            r[k*WIDTH +: WIDTH] = WIDTH'(acc);
        end
        return r;
    endfunction

    function automatic logic below_q(input logic [DW-1:0] d);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < 8; k++)
            if (int'(d[k*WIDTH +: WIDTH]) >= Q) ok = 1'b0;
        return ok;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic sample();
        if (stalled) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_data", 64'(out_data), 64'(held));
        end
        if (out_valid) begin
            check("below_q", 64'(below_q(out_data)), 64'd1);
            if (!out_ready) check("stall_in_ready", 64'(in_ready), 64'd0);
            if (exp_q.size() == 0) check("spurious_out", 64'(out_valid), 64'd0);
            else if (out_ready) begin
                check("out_data", 64'(out_data), 64'(exp_q.pop_front()));
                outs++;
            end
        end
        accepted = in_valid && in_ready;
        if (accepted) exp_q.push_back(pending_exp);
        stalled = out_valid && !out_ready;
        held    = out_data;
    endtask

    task automatic step();
        #1;
        sample();
        @(negedge clk);
    endtask

    task automatic new_beat(input logic m);
        logic [DW-1:0] xd;
        logic [TW-1:0] td;
        for (int k = 0; k < 8; k++) xd[k*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, Q-1));
        for (int k = 0; k < 7; k++) td[k*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, Q-1));
        in_mode     = m;
        in_data     = xd;
        in_twiddle  = td;
        pending_exp = model(m, xd, td);
    endtask

    task automatic run_stream(input int nbeats, input logic random_hs, input int budget);
        int sent;
        int cyc;
        int outs0;
        sent  = 0;
        cyc   = 0;
        outs0 = outs;
        new_beat(random_hs ? 1'($urandom_range(0, 1)) : 1'b0);
        while (sent < nbeats && cyc < budget) begin
            in_valid  = random_hs ? 1'($urandom_range(0, 1)) : 1'b1;
            out_ready = random_hs ? 1'($urandom_range(0, 1)) : !(cyc >= 6 && cyc < 9);
            step();
            cyc++;
            if (accepted) begin
                sent++;
                new_beat(random_hs ? 1'($urandom_range(0, 1)) : 1'(sent % 2));
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 40) begin
            step();
            cyc++;
        end
        check("beats_sent", 64'(sent), 64'(nbeats));
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        check("beat_count", 64'(outs - outs0), 64'(nbeats));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, expected to end", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[7];
        int   lat;

        vecs[0] = mk(1'b0, p8(1, 0, 0, 0, 0, 0, 0, 0), p7(1, 1, 1, 1, 1, 1, 1),
                     p8(1, 1, 1, 1, 1, 1, 1, 1));
        vecs[1] = mk(1'b0, p8(0, 1, 0, 0, 0, 0, 0, 0), p7(3, 1, 1, 1, 1, 1, 1),
                     p8(3, 6, 12, 7, 14, 11, 5, 10));
        vecs[2] = mk(1'b1, p8(1, 2, 4, 8, 16, 15, 13, 9), p7(1, 1, 1, 1, 1, 1, 1),
                     p8(0, 8, 0, 0, 0, 0, 0, 0));
        vecs[3] = mk(1'b0, p8(1, 1, 1, 1, 1, 1, 1, 1), p7(1, 1, 1, 1, 1, 1, 1),
                     p8(8, 0, 0, 0, 0, 0, 0, 0));
        vecs[4] = mk(1'b1, p8(0, 1, 0, 0, 0, 0, 0, 0), p7(1, 1, 1, 1, 1, 1, 1),
                     p8(1, 9, 13, 15, 16, 8, 4, 2));
        vecs[5] = mk(1'b1, p8(1, 0, 0, 0, 0, 0, 0, 0), p7(2, 3, 4, 5, 6, 7, 8),
                     p8(1, 2, 3, 4, 5, 6, 7, 8));
        vecs[6] = mk(1'b0, p8(16, 16, 16, 16, 16, 16, 16, 16), p7(16, 16, 16, 16, 16, 16, 16),
                     p8(6, 15, 15, 15, 15, 15, 15, 15));

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            in_valid    = 1'b1;
            in_mode     = vecs[i].mode;
            in_data     = vecs[i].x;
            in_twiddle  = vecs[i].t;
            pending_exp = vecs[i].y;
            step();
            in_valid = 1'b0;
            lat = 1;
            while (lat < 12) begin
                #1;
                if (out_valid) break;
                sample();
                @(negedge clk);
                lat++;
            end
            check("latency", 64'(lat), 64'd5);
            if (lat < 12) begin
                sample();
                @(negedge clk);
            end
        end

        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            new_beat(1'(i % 2));
            step();
        end
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_data", 64'(out_data), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        stalled = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        repeat (10) step();

        run_stream(20, 1'b0, 200);
        run_stream(1000, 1'b1, 20000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
